// File: rtl/key_sequence_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_sequence_decoder_pkg
// Description : Keyboard sequence format constants shared by encoder/decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package key_sequence_decoder_pkg;

    localparam logic [7:0] SEQ_PREFIX     = 8'h1F;
    localparam logic [2:0] SEQ_MOD_HEADER = 3'b010;

    localparam int MOD_SHIFT = 0;
    localparam int MOD_CTRL  = 1;
    localparam int MOD_ALT   = 2;
    localparam int MOD_ALTGR = 3;
    localparam int MOD_META  = 4;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREFIX   = 2'd1;
    localparam logic [1:0] ST_MODIFIER = 2'd2;

    function automatic logic is_mod_header(input logic [7:0] b);
        return (b[7:5] == SEQ_MOD_HEADER);
    endfunction

    function automatic logic [4:0] extract_mods(input logic [7:0] b);
        logic [4:0] m;
        m            = 5'd0;
        m[MOD_SHIFT] = b[MOD_SHIFT];
        m[MOD_CTRL]  = b[MOD_CTRL];
        m[MOD_ALT]   = b[MOD_ALT];
        m[MOD_ALTGR] = b[MOD_ALTGR];
        m[MOD_META]  = b[MOD_META];
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_sequence_decoder.sv
`default_nettype none
// ============================================================================
// Module      : key_sequence_decoder
// Description : Reassembles plain / 3-byte extended key sequences into events.
// Revision    : 1.0 - initial release
// ============================================================================
module key_sequence_decoder
    import key_sequence_decoder_pkg::*;
#(
    parameter logic [7:0] PREFIX         = SEQ_PREFIX,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter int         TIMER_WIDTH    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_in_valid,
    output logic       byte_in_ready,
    output logic       event_valid,
    input  logic       event_ready,
    output logic       event_extended,
    output logic [7:0] event_code,
    output logic [4:0] event_modifier,
    output logic       error_pulse,
    output logic [7:0] error_count
);

    localparam logic [TIMER_WIDTH-1:0] c_TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [1:0]             r_state;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic [4:0]             r_mod;
    logic                   r_event_valid;
    logic                   r_event_extended;
    logic [7:0]             r_event_code;
    logic [4:0]             r_event_modifier;
    logic                   r_error_pulse;
    logic [7:0]             r_error_count;

    logic                   w_accept;
    logic [1:0]             w_state_nxt;
    logic [TIMER_WIDTH-1:0] w_timer_nxt;
    logic                   w_emit;
    logic                   w_emit_ext;
    logic                   w_mod_load;
    logic                   w_error;

    assign w_accept = byte_in_valid && !r_event_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_emit      = 1'b0;
        w_emit_ext  = 1'b0;
        w_mod_load  = 1'b0;
        w_error     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_timer_nxt = '0;
                if (w_accept) begin
                    if (byte_in == PREFIX) begin
                        w_state_nxt = ST_PREFIX;
                    end else begin
                        w_emit = 1'b1;
                    end
                end
            end
            ST_PREFIX, ST_MODIFIER: begin
                // An accept in the final timer cycle takes priority over timeout.
                if (w_accept) begin
                    w_timer_nxt = '0;
                    if (r_state == ST_MODIFIER) begin
                        w_emit      = 1'b1;
                        w_emit_ext  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (is_mod_header(byte_in)) begin
                        w_mod_load  = 1'b1;
                        w_state_nxt = ST_MODIFIER;
                    end else begin
                        w_error     = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_timer == c_TIMER_LAST) begin
                    w_error     = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_timer          <= '0;
            r_mod            <= 5'd0;
            r_event_valid    <= 1'b0;
            r_event_extended <= 1'b0;
            r_event_code     <= 8'd0;
            r_event_modifier <= 5'd0;
            r_error_pulse    <= 1'b0;
            r_error_count    <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_error_pulse <= w_error;
            if (w_mod_load) begin
                r_mod <= extract_mods(byte_in);
            end
            if (w_error && (r_error_count != 8'hFF)) begin
                r_error_count <= r_error_count + 8'd1;
            end
            // Emission requires an accept, which cannot happen while an event is pending.
            if (w_emit) begin
                r_event_valid    <= 1'b1;
                r_event_extended <= w_emit_ext;
                r_event_code     <= byte_in;
                r_event_modifier <= w_emit_ext ? r_mod : 5'd0;
            end else if (r_event_valid && event_ready) begin
                r_event_valid <= 1'b0;
            end
        end
    end

    assign byte_in_ready  = !r_event_valid;
    assign event_valid    = r_event_valid;
    assign event_extended = r_event_extended;
    assign event_code     = r_event_code;
    assign event_modifier = r_event_modifier;
    assign error_pulse    = r_error_pulse;
    assign error_count    = r_error_count;

endmodule
`default_nettype wire
